coherence_ctrl: RTL and testbench

// - Parametrised per-cache coherence controller; successor to separate single-line CPU-side/bus-side MSI FSMs.
// - Holds an NUM_LINES-entry direct-mapped tag/state array and one CPU-side transaction FSM on a single clock.
// - Applies bus snoops to the array every cycle.
// - Sits between a cpu/cache_block pair and the shared snooping bus/memory.

---
 rtl/coherence_pkg.sv | 50 +++++
 rtl/coherence_line_array.sv | 83 ++++++++
 rtl/coherence_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_coherence_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/coherence_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coherence_pkg
// Purpose  : Shared encodings for the snooping coherence controller: line
//            states, bus/snoop command codes, CPU-side FSM state type, and
//            the snoop next-state function used by the line array.
// Ports    : none (package)
// Config   : COHERENCE_MESI_EN (consumed by coherence_ctrl) enables state E
// Revision : 1.0 - initial release
// ============================================================================
package coherence_pkg;

  // Line states as seen on dbg_state
  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;
  localparam logic [1:0] ST_E = 2'b11;

  // Bus and snoop command codes
  localparam logic [1:0] CMD_WRITE_BACK = 2'b00;
  localparam logic [1:0] CMD_READ_MISS  = 2'b01;
  localparam logic [1:0] CMD_WRITE_MISS = 2'b10;
  localparam logic [1:0] CMD_INVALIDATE = 2'b11;

  // CPU-side transaction FSM
  typedef enum logic [2:0] {
    FSM_IDLE = 3'd0,
    FSM_WB   = 3'd1,
    FSM_MISS = 3'd2,
    FSM_UPG  = 3'd3,
    FSM_DONE = 3'd4
  } fsm_state_t;

  // State of a valid, tag-matching line after a snooped command.
  // INVALIDATE on M is a protocol error; the line is simply dropped.
  function automatic logic [1:0] snoop_next_state(input logic [1:0] cur,
                                                  input logic [1:0] cmd);
    logic [1:0] nxt;
    nxt = cur;
    case (cmd)
      CMD_READ_MISS:  if (cur == ST_M || cur == ST_E) nxt = ST_S;
      CMD_WRITE_MISS: nxt = ST_I;
      CMD_INVALIDATE: nxt = ST_I;
      default:        nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coherence_line_array.sv
`default_nettype none
// ============================================================================
// Module   : coherence_line_array
// Purpose  : Direct-mapped tag/state storage with one CPU lookup/write port
//            and one snoop port. Snoops update the array every cycle; the
//            CPU lookup returns the post-snoop state of its line.
// Ports    : clock, reset_n        - clock, async active-low reset
//            idx                   - CPU-side line select (lookup and write)
//            look_tag, look_state  - tag and post-snoop state of line idx
//            wr_en/wr_tag/wr_state - CPU-side line update
//            snoop_valid/cmd/addr  - snooped transaction
//            snoop_write_back      - this cache holds the snooped line dirty
//            dbg_idx, dbg_state    - registered state of any line
// Revision : 1.0 - initial release
// ============================================================================
module coherence_line_array
  import coherence_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int ADDR_W    = 8
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [$clog2(NUM_LINES)-1:0]     idx,
  output logic [ADDR_W-$clog2(NUM_LINES)-1:0] look_tag,
  output logic [1:0]                       look_state,
  input  logic                             wr_en,
  input  logic [ADDR_W-$clog2(NUM_LINES)-1:0] wr_tag,
  input  logic [1:0]                       wr_state,
  input  logic                             snoop_valid,
  input  logic [1:0]                       snoop_cmd,
  input  logic [ADDR_W-1:0]                snoop_addr,
  output logic                             snoop_write_back,
  input  logic [$clog2(NUM_LINES)-1:0]     dbg_idx,
  output logic [1:0]                       dbg_state
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [TAG_W-1:0] tags   [NUM_LINES];
  logic [1:0]       states [NUM_LINES];

  logic [IDX_W-1:0] snoop_idx;
  logic [TAG_W-1:0] snoop_tag;
  logic             snoop_hit;
  logic [1:0]       snoop_next;

  assign snoop_idx = snoop_addr[IDX_W-1:0];
  assign snoop_tag = snoop_addr[ADDR_W-1:IDX_W];
  assign snoop_hit = snoop_valid && (tags[snoop_idx] == snoop_tag) &&
                     (states[snoop_idx] != ST_I);
  assign snoop_next = snoop_next_state(states[snoop_idx], snoop_cmd);

  // Only a dirty line is supplied; E and S are clean.
  assign snoop_write_back = snoop_hit && (states[snoop_idx] == ST_M) &&
                            (snoop_cmd == CMD_READ_MISS || snoop_cmd == CMD_WRITE_MISS);

  assign look_tag   = tags[idx];
  assign look_state = (snoop_hit && snoop_idx == idx) ? snoop_next : states[idx];
  assign dbg_state  = states[dbg_idx];

  // CPU write already accounts for the post-snoop view, so it wins on a clash.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        tags[i]   <= '0;
        states[i] <= ST_I;
      end
    end else begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (wr_en && idx == IDX_W'(i)) begin
          tags[i]   <= wr_tag;
          states[i] <= wr_state;
        end else if (snoop_hit && snoop_idx == IDX_W'(i)) begin
          states[i] <= snoop_next;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/coherence_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : coherence_ctrl
// Purpose  : Per-cache snooping coherence controller: direct-mapped line
//            array plus one CPU-side transaction FSM (IDLE/WB/MISS/UPG/DONE)
//            driving a registered bus request interface.
// Ports    : clock, reset_n                  - clock, async active-low reset
//            cpu_req/write/addr, cpu_done/hit - CPU access handshake
//            bus_req/cmd/addr, bus_gnt        - shared bus request/grant
//            bus_shared (MESI only)           - other cache holds the line
//            snoop_valid/cmd/addr             - snooped transaction
//            snoop_write_back, snoop_abort    - supply dirty line / abort mem
//            dbg_idx, dbg_state               - line state display
// Config   : `define COHERENCE_MESI_EN adds state E and the bus_shared input;
//            default build is pure MSI.
// Revision : 1.0 - initial release
// ============================================================================
module coherence_ctrl
  import coherence_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int ADDR_W    = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         cpu_req,
  input  logic                         cpu_write,
  input  logic [ADDR_W-1:0]            cpu_addr,
  output logic                         cpu_done,
  output logic                         cpu_hit,
  output logic                         bus_req,
  output logic [1:0]                   bus_cmd,
  output logic [ADDR_W-1:0]            bus_addr,
  input  logic                         bus_gnt,
`ifdef COHERENCE_MESI_EN
  input  logic                         bus_shared,
`endif
  input  logic                         snoop_valid,
  input  logic [1:0]                   snoop_cmd,
  input  logic [ADDR_W-1:0]            snoop_addr,
  output logic                         snoop_write_back,
  output logic                         snoop_abort,
  input  logic [$clog2(NUM_LINES)-1:0] dbg_idx,
  output logic [1:0]                   dbg_state
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  fsm_state_t        state, state_n;
  logic              bus_req_n;
  logic [1:0]        bus_cmd_n;
  logic [ADDR_W-1:0] bus_addr_n;
  logic [ADDR_W-1:0] req_addr, req_addr_n;
  logic              req_write, req_write_n;
  logic              hit_q, hit_n;

  logic [IDX_W-1:0]  look_idx;
  logic [TAG_W-1:0]  cmp_tag;
  logic [TAG_W-1:0]  look_tag;
  logic [1:0]        look_state;
  logic              line_hit;
  logic              wr_en;
  logic [TAG_W-1:0]  wr_tag;
  logic [1:0]        wr_state;
  logic [1:0]        fill_state;

  // In IDLE the live CPU address is looked up; afterwards the latched one.
  assign look_idx = (state == FSM_IDLE) ? cpu_addr[IDX_W-1:0] : req_addr[IDX_W-1:0];
  assign cmp_tag  = (state == FSM_IDLE) ? cpu_addr[ADDR_W-1:IDX_W] : req_addr[ADDR_W-1:IDX_W];
  assign line_hit = (look_tag == cmp_tag) && (look_state != ST_I);

`ifdef COHERENCE_MESI_EN
  assign fill_state = req_write ? ST_M : (bus_shared ? ST_S : ST_E);
`else
  assign fill_state = req_write ? ST_M : ST_S;
`endif

  coherence_line_array #(
    .NUM_LINES (NUM_LINES),
    .ADDR_W    (ADDR_W)
  ) u_array (
    .clock            (clock),
    .reset_n          (reset_n),
    .idx              (look_idx),
    .look_tag         (look_tag),
    .look_state       (look_state),
    .wr_en            (wr_en),
    .wr_tag           (wr_tag),
    .wr_state         (wr_state),
    .snoop_valid      (snoop_valid),
    .snoop_cmd        (snoop_cmd),
    .snoop_addr       (snoop_addr),
    .snoop_write_back (snoop_write_back),
    .dbg_idx          (dbg_idx),
    .dbg_state        (dbg_state)
  );

  assign snoop_abort = snoop_write_back;
  assign cpu_done    = (state == FSM_DONE);
  assign cpu_hit     = cpu_done && hit_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FSM_IDLE;
      bus_req   <= 1'b0;
      bus_cmd   <= CMD_WRITE_BACK;
      bus_addr  <= '0;
      req_addr  <= '0;
      req_write <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state     <= state_n;
      bus_req   <= bus_req_n;
      bus_cmd   <= bus_cmd_n;
      bus_addr  <= bus_addr_n;
      req_addr  <= req_addr_n;
      req_write <= req_write_n;
      hit_q     <= hit_n;
    end
  end

  always_comb begin
    state_n     = state;
    bus_req_n   = bus_req;
    bus_cmd_n   = bus_cmd;
    bus_addr_n  = bus_addr;
    req_addr_n  = req_addr;
    req_write_n = req_write;
    hit_n       = hit_q;
    wr_en       = 1'b0;
    wr_tag      = look_tag;
    wr_state    = look_state;

    case (state)
      FSM_IDLE: begin
        if (cpu_req) begin
          req_addr_n  = cpu_addr;
          req_write_n = cpu_write;
          hit_n       = 1'b0;
          if (line_hit && (!cpu_write || look_state == ST_M)) begin
            state_n = FSM_DONE;
            hit_n   = 1'b1;
`ifdef COHERENCE_MESI_EN
          end else if (line_hit && look_state == ST_E) begin
            // Exclusive clean line: upgrade locally, no bus traffic.
            wr_en    = 1'b1;
            wr_state = ST_M;
            state_n  = FSM_DONE;
            hit_n    = 1'b1;
`endif
          end else if (line_hit) begin
            state_n    = FSM_UPG;
            bus_req_n  = 1'b1;
            bus_cmd_n  = CMD_INVALIDATE;
            bus_addr_n = cpu_addr;
          end else if (look_state == ST_M) begin
            state_n    = FSM_WB;
            bus_req_n  = 1'b1;
            bus_cmd_n  = CMD_WRITE_BACK;
            bus_addr_n = {look_tag, cpu_addr[IDX_W-1:0]};
          end else begin
            state_n    = FSM_MISS;
            bus_req_n  = 1'b1;
            bus_cmd_n  = cpu_write ? CMD_WRITE_MISS : CMD_READ_MISS;
            bus_addr_n = cpu_addr;
          end
        end
      end

      FSM_WB: begin
        // Completes unchanged even if a snoop demoted the victim meanwhile.
        if (bus_gnt) begin
          wr_en      = 1'b1;
          wr_state   = ST_I;
          state_n    = FSM_MISS;
          bus_cmd_n  = req_write ? CMD_WRITE_MISS : CMD_READ_MISS;
          bus_addr_n = req_addr;
        end
      end

      FSM_MISS: begin
        if (bus_gnt) begin
          wr_en     = 1'b1;
          wr_tag    = req_addr[ADDR_W-1:IDX_W];
          wr_state  = fill_state;
          bus_req_n = 1'b0;
          state_n   = FSM_DONE;
        end
      end

      FSM_UPG: begin
        // Line lost to a snoop before grant: request stays up as a write miss.
        if (!line_hit) begin
          bus_cmd_n = CMD_WRITE_MISS;
          state_n   = FSM_MISS;
        end else if (bus_gnt) begin
          wr_en     = 1'b1;
          wr_state  = ST_M;
          bus_req_n = 1'b0;
          state_n   = FSM_DONE;
        end
      end

      FSM_DONE: state_n = FSM_IDLE;

      default: state_n = FSM_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_coherence_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_coherence_ctrl
// Purpose  : Directed self-checking bench for coherence_ctrl (NUM_LINES=4,
//            ADDR_W=8). MESI scenario included when COHERENCE_MESI_EN set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coherence_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_req = 1'b0, cpu_write = 1'b0;
  logic [7:0] cpu_addr = '0;
  logic       cpu_done, cpu_hit, bus_req;
  logic [1:0] bus_cmd;
  logic [7:0] bus_addr;
  logic       bus_gnt = 1'b0;
`ifdef COHERENCE_MESI_EN
  logic       bus_shared = 1'b1;
`endif
  logic       snoop_valid = 1'b0;
  logic [1:0] snoop_cmd = '0;
  logic [7:0] snoop_addr = '0;
  logic       snoop_write_back, snoop_abort;
  logic [1:0] dbg_idx = 2'd1;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  coherence_ctrl #(.NUM_LINES(4), .ADDR_W(8)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .cpu_req          (cpu_req),
    .cpu_write        (cpu_write),
    .cpu_addr         (cpu_addr),
    .cpu_done         (cpu_done),
    .cpu_hit          (cpu_hit),
    .bus_req          (bus_req),
    .bus_cmd          (bus_cmd),
    .bus_addr         (bus_addr),
    .bus_gnt          (bus_gnt),
`ifdef COHERENCE_MESI_EN
    .bus_shared       (bus_shared),
`endif
    .snoop_valid      (snoop_valid),
    .snoop_cmd        (snoop_cmd),
    .snoop_addr       (snoop_addr),
    .snoop_write_back (snoop_write_back),
    .snoop_abort      (snoop_abort),
    .dbg_idx          (dbg_idx),
    .dbg_state        (dbg_state)
  );

  always #5 clock = ~clock;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cpu_req = 1'b0;
    bus_gnt = 1'b0;
    snoop_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (cpu_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", cpu_done); end
    total++; if (cpu_hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b exp=0", cpu_hit); end
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL reset_bus_req got=%b exp=0", bus_req); end
    total++; if (bus_cmd !== 2'b00) begin bad++; $display("FAIL reset_bus_cmd got=%b exp=00", bus_cmd); end
    total++; if (bus_addr !== 8'h00) begin bad++; $display("FAIL reset_bus_addr got=%h exp=00", bus_addr); end
    total++; if (snoop_write_back !== 1'b0) begin bad++; $display("FAIL reset_snoop_wb got=%b exp=0", snoop_write_back); end
    for (int i = 0; i < 4; i++) begin
      dbg_idx = 2'(i);
      #1;
      total++; if (dbg_state !== 2'b00) begin bad++; $display("FAIL reset_line%0d got=%b exp=00", i, dbg_state); end
    end
    dbg_idx = 2'd1;
  endtask

  task automatic test_read_miss_hit();
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h05;
    tick();
    total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL rd_miss_req got=%b exp=1", bus_req); end
    total++; if (bus_cmd !== 2'b01) begin bad++; $display("FAIL rd_miss_cmd got=%b exp=01", bus_cmd); end
    total++; if (bus_addr !== 8'h05) begin bad++; $display("FAIL rd_miss_addr got=%h exp=05", bus_addr); end
    total++; if (cpu_done !== 1'b0) begin bad++; $display("FAIL rd_miss_early_done got=%b exp=0", cpu_done); end
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    total++; if ({cpu_done, cpu_hit} !== 2'b10) begin bad++; $display("FAIL rd_miss_done got=%b exp=10", {cpu_done, cpu_hit}); end
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rd_miss_req_drop got=%b exp=0", bus_req); end
    total++; if (dbg_state !== 2'b01) begin bad++; $display("FAIL rd_miss_state got=%b exp=01", dbg_state); end
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1;
    tick();
    total++; if ({cpu_done, cpu_hit} !== 2'b11) begin bad++; $display("FAIL rd_hit got=%b exp=11", {cpu_done, cpu_hit}); end
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rd_hit_bus got=%b exp=0", bus_req); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_write_upgrade();
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 8'h05;
    tick();
    total++; if ({bus_req, bus_cmd} !== 3'b111) begin bad++; $display("FAIL upg_req got=%b exp=111", {bus_req, bus_cmd}); end
    total++; if (bus_addr !== 8'h05) begin bad++; $display("FAIL upg_addr got=%h exp=05", bus_addr); end
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    total++; if ({cpu_done, cpu_hit} !== 2'b10) begin bad++; $display("FAIL upg_done got=%b exp=10", {cpu_done, cpu_hit}); end
    total++; if (dbg_state !== 2'b10) begin bad++; $display("FAIL upg_state got=%b exp=10", dbg_state); end
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1;
    tick();
    total++; if ({cpu_done, cpu_hit, bus_req} !== 3'b110) begin bad++; $display("FAIL wr_hit got=%b exp=110", {cpu_done, cpu_hit, bus_req}); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_writeback();
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h09;
    tick();
    total++; if ({bus_req, bus_cmd} !== 3'b100) begin bad++; $display("FAIL wb_req got=%b exp=100", {bus_req, bus_cmd}); end
    total++; if (bus_addr !== 8'h05) begin bad++; $display("FAIL wb_addr got=%h exp=05", bus_addr); end
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    total++; if ({bus_req, bus_cmd} !== 3'b101) begin bad++; $display("FAIL wb_miss_req got=%b exp=101", {bus_req, bus_cmd}); end
    total++; if (bus_addr !== 8'h09) begin bad++; $display("FAIL wb_miss_addr got=%h exp=09", bus_addr); end
    total++; if (dbg_state !== 2'b00) begin bad++; $display("FAIL wb_victim_state got=%b exp=00", dbg_state); end
    total++; if (cpu_done !== 1'b0) begin bad++; $display("FAIL wb_early_done got=%b exp=0", cpu_done); end
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    total++; if ({cpu_done, cpu_hit} !== 2'b10) begin bad++; $display("FAIL wb_done got=%b exp=10", {cpu_done, cpu_hit}); end
    total++; if (dbg_state !== 2'b01) begin bad++; $display("FAIL wb_fill_state got=%b exp=01", dbg_state); end
    cpu_req = 1'b0;
    tick();
    // A hit on 0x09 shows the line now carries tag 0x02.
    cpu_req = 1'b1;
    tick();
    total++; if ({cpu_done, cpu_hit} !== 2'b11) begin bad++; $display("FAIL wb_tag_hit got=%b exp=11", {cpu_done, cpu_hit}); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_snoop();
    // Line1 holds 0x09 in S; a write to 0x05 misses without a write-back.
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 8'h05;
    tick();
    total++; if ({bus_req, bus_cmd} !== 3'b110) begin bad++; $display("FAIL snp_wmiss_req got=%b exp=110", {bus_req, bus_cmd}); end
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    cpu_req = 1'b0;
    tick();
    total++; if (dbg_state !== 2'b10) begin bad++; $display("FAIL snp_setup_m got=%b exp=10", dbg_state); end
    snoop_valid = 1'b1; snoop_cmd = 2'b01; snoop_addr = 8'h09;
    #1;
    total++; if (snoop_write_back !== 1'b0) begin bad++; $display("FAIL snp_tag_miss_wb got=%b exp=0", snoop_write_back); end
    snoop_addr = 8'h05;
    #1;
    total++; if ({snoop_write_back, snoop_abort} !== 2'b11) begin bad++; $display("FAIL snp_rm_wb got=%b exp=11", {snoop_write_back, snoop_abort}); end
    tick();
    snoop_valid = 1'b0;
    total++; if (dbg_state !== 2'b01) begin bad++; $display("FAIL snp_rm_state got=%b exp=01", dbg_state); end
    snoop_valid = 1'b1; snoop_cmd = 2'b10; snoop_addr = 8'h05;
    #1;
    total++; if ({snoop_write_back, snoop_abort} !== 2'b00) begin bad++; $display("FAIL snp_wm_s_wb got=%b exp=00", {snoop_write_back, snoop_abort}); end
    tick();
    snoop_valid = 1'b0;
    total++; if (dbg_state !== 2'b00) begin bad++; $display("FAIL snp_wm_state got=%b exp=00", dbg_state); end
  endtask

  task automatic test_upg_convert();
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h05;
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_write = 1'b1;
    tick();
    total++; if ({bus_req, bus_cmd} !== 3'b111) begin bad++; $display("FAIL cvt_upg got=%b exp=111", {bus_req, bus_cmd}); end
    snoop_valid = 1'b1; snoop_cmd = 2'b11; snoop_addr = 8'h05;
    tick();
    snoop_valid = 1'b0;
    total++; if ({bus_req, bus_cmd} !== 3'b110) begin bad++; $display("FAIL cvt_cmd got=%b exp=110", {bus_req, bus_cmd}); end
    total++; if (bus_addr !== 8'h05) begin bad++; $display("FAIL cvt_addr got=%h exp=05", bus_addr); end
    total++; if (dbg_state !== 2'b00) begin bad++; $display("FAIL cvt_inval_state got=%b exp=00", dbg_state); end
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    total++; if ({cpu_done, cpu_hit} !== 2'b10) begin bad++; $display("FAIL cvt_done got=%b exp=10", {cpu_done, cpu_hit}); end
    total++; if (dbg_state !== 2'b10) begin bad++; $display("FAIL cvt_state got=%b exp=10", dbg_state); end
    cpu_req = 1'b0;
    tick();
  endtask

`ifdef COHERENCE_MESI_EN
  task automatic test_mesi();
    do_reset();
    bus_shared = 1'b0;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h05;
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    bus_shared = 1'b1;
    total++; if (dbg_state !== 2'b11) begin bad++; $display("FAIL mesi_e_fill got=%b exp=11", dbg_state); end
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_write = 1'b1;
    tick();
    total++; if ({cpu_done, cpu_hit, bus_req} !== 3'b110) begin bad++; $display("FAIL mesi_e_write got=%b exp=110", {cpu_done, cpu_hit, bus_req}); end
    total++; if (dbg_state !== 2'b10) begin bad++; $display("FAIL mesi_e_to_m got=%b exp=10", dbg_state); end
    cpu_req = 1'b0;
    tick();
  endtask
`endif

  task automatic test_reset_mid_miss();
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h0A;
    tick();
    total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL rst_pre_req got=%b exp=1", bus_req); end
    reset_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rst_bus_req got=%b exp=0", bus_req); end
    total++; if (dbg_state !== 2'b00) begin bad++; $display("FAIL rst_line1 got=%b exp=00", dbg_state); end
    tick();
    total++; if (cpu_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", cpu_done); end
    reset_n = 1'b1;
    tick();
    total++; if ({cpu_done, bus_req} !== 2'b00) begin bad++; $display("FAIL rst_after got=%b exp=00", {cpu_done, bus_req}); end
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_upgrade();
    test_writeback();
    test_snoop();
    test_upg_convert();
`ifdef COHERENCE_MESI_EN
    test_mesi();
`endif
    test_reset_mid_miss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
